// File: rtl/sd_hc_pkg.sv
// Shared SD host constants: clock FSM state encoding and clk_ctrl field positions.
package sd_hc_pkg;
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_STAB  = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  localparam int ICE    = 0;
  localparam int ICS    = 1;
  localparam int SCE    = 2;
  localparam int FS_LSB = 8;
endpackage

// File: rtl/sd_clk_div.sv
// Half-period counter and SDCLK toggle flop with registered rise/fall strobes.
// Held cleared (sd_clk low) whenever run is low; the half-period length is
// sampled only while idle and at each toggle, so a divider change never cuts a phase.
module sd_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             ex_clk,
  input  logic             ex_reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tc,
  output logic             sd_clk,
  output logic             rise,
  output logic             fall
);
  logic [DIV_W-1:0] cnt, hp, hp_nxt;

  // N=0 behaves as N=1, so the terminal count is max(N,1)-1
  assign hp_nxt = (div == '0) ? '0 : div - DIV_W'(1);
  assign tc     = run && (cnt == hp);

  always_ff @(posedge ex_clk) begin
    if (ex_reset) begin
      cnt    <= '0;
      hp     <= '0;
      sd_clk <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      hp     <= hp_nxt;
      sd_clk <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (tc) begin
      cnt    <= '0;
      hp     <= hp_nxt;
      sd_clk <= ~sd_clk;
      rise   <= ~sd_clk;
      fall   <= sd_clk;
    end else begin
      cnt    <= cnt + DIV_W'(1);
      rise   <= 1'b0;
      fall   <= 1'b0;
    end
  end
endmodule

// File: rtl/sd_clk_gen.sv
// SD host clock control: clk_ctrl register, stabilisation FSM and divided SDCLK.
// Optional SD_CLK_AUTO_STOP_EN adds the PAUSE state driven by stop_req.
module sd_clk_gen
  import sd_hc_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic        ex_clk,
  input  logic        ex_reset,
  input  logic [15:0] clk_ctrl_in,
  input  logic        clk_ctrl_wr,
  output logic [15:0] clk_ctrl_out,
  input  logic        stop_req,
  output logic        sd_clk,
  output logic        sd_clk_rise,
  output logic        sd_clk_fall,
  output logic        clk_paused
);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             ice, sce, ice_nxt, sce_nxt, stable, tc, div_run;
  logic [DIV_W-1:0] fs, fs_nxt;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] stab_cnt;

  // The FSM decodes the value being committed this edge, so a write acts
  // in the same cycle its readback becomes visible.
  assign ice_nxt = clk_ctrl_wr ? clk_ctrl_in[ICE] : ice;
  assign sce_nxt = clk_ctrl_wr ? clk_ctrl_in[SCE] : sce;
  assign fs_nxt  = clk_ctrl_wr ? clk_ctrl_in[FS_LSB +: DIV_W] : fs;

  always_ff @(posedge ex_clk) begin
    if (ex_reset) begin
      ice <= 1'b0;
      sce <= 1'b0;
      fs  <= '0;
    end else begin
      ice <= ice_nxt;
      sce <= sce_nxt;
      fs  <= fs_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_OFF:   if (ice_nxt) state_nxt = ST_STAB;
      ST_STAB:  if (!ice_nxt) state_nxt = ST_OFF;
                else if (stab_cnt == STAB_LAST) state_nxt = ST_READY;
      ST_READY: if (!ice_nxt) state_nxt = ST_OFF;
                else if (sce_nxt) state_nxt = ST_RUN;
      // stop leaves on the falling toggle when high, at once when low unless
      // a rising toggle is already due
      ST_RUN:   if (!ice_nxt) state_nxt = ST_OFF;
                else if (!sce_nxt && (sd_clk ? tc : !tc)) state_nxt = ST_READY;
`ifdef SD_CLK_AUTO_STOP_EN
                else if (stop_req && tc && sd_clk) state_nxt = ST_PAUSE;
      ST_PAUSE: if (!ice_nxt) state_nxt = ST_OFF;
                else if (!sce_nxt) state_nxt = ST_READY;
                else if (!stop_req) state_nxt = ST_RUN;
`endif
      default:  state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge ex_clk) begin
    if (ex_reset) begin
      state    <= ST_OFF;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= (state == ST_STAB && state_nxt == ST_STAB) ? stab_cnt + CNT_W'(1) : '0;
    end
  end

  assign stable  = (state == ST_READY) || (state == ST_RUN) || (state == ST_PAUSE);
  assign div_run = (state == ST_RUN) && ice_nxt;

  sd_clk_div #(.DIV_W(DIV_W)) u_div (
    .ex_clk   (ex_clk),
    .ex_reset (ex_reset),
    .run      (div_run),
    .div      (fs_nxt),
    .tc       (tc),
    .sd_clk   (sd_clk),
    .rise     (sd_clk_rise),
    .fall     (sd_clk_fall)
  );

  always_comb begin
    clk_ctrl_out                   = '0;
    clk_ctrl_out[ICE]              = ice;
    clk_ctrl_out[ICS]              = stable;
    clk_ctrl_out[SCE]              = sce;
    clk_ctrl_out[FS_LSB +: DIV_W]  = fs;
  end

  logic unused_in;
  assign unused_in = ^{clk_ctrl_in[7:3], clk_ctrl_in[ICS]};

`ifdef SD_CLK_AUTO_STOP_EN
  assign clk_paused = (state == ST_PAUSE);
`else
  logic unused_stop;
  assign unused_stop = stop_req;
  assign clk_paused  = 1'b0;
`endif
endmodule

// File: tb/tb_sd_clk_gen.sv
// Scoreboard bench for sd_clk_gen: a countdown-based reference model predicts
// every cycle's outputs; a monitor pops and compares one entry per clock.
module tb_sd_clk_gen;
  localparam int STABLE_CYCLES = 16;
`ifdef SD_CLK_AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_OFF = 0, M_STAB = 1, M_READY = 2, M_RUN = 3, M_PAUSE = 4;

  logic        ex_clk = 1'b0, ex_reset, clk_ctrl_wr, stop_req;
  logic [15:0] clk_ctrl_in, clk_ctrl_out;
  logic        sd_clk, sd_clk_rise, sd_clk_fall, clk_paused;

  sd_clk_gen #(.DIV_W(8), .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(16)) dut (
    .ex_clk       (ex_clk),
    .ex_reset     (ex_reset),
    .clk_ctrl_in  (clk_ctrl_in),
    .clk_ctrl_wr  (clk_ctrl_wr),
    .clk_ctrl_out (clk_ctrl_out),
    .stop_req     (stop_req),
    .sd_clk       (sd_clk),
    .sd_clk_rise  (sd_clk_rise),
    .sd_clk_fall  (sd_clk_fall),
    .clk_paused   (clk_paused)
  );

  always #5 ex_clk = ~ex_clk;

  // reference model state
  logic       m_ice = 0, m_sce = 0, m_sd = 0, m_rise = 0, m_fall = 0;
  logic [7:0] m_n = 0;
  int         m_mode = M_OFF, m_stab_left = 0, m_left = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0, n_fail = 0, n_cyc = 0;
  logic        stop_lvl = 0;

  task automatic model_step(input logic r, input logic w, input logic [15:0] d, input logic s);
    logic ice_n, sce_n;
    logic [7:0] n_n;
    int half;
    m_rise = 0;
    m_fall = 0;
    if (r) begin
      m_ice = 0; m_sce = 0; m_n = 0; m_sd = 0;
      m_mode = M_OFF; m_stab_left = 0; m_left = 0;
      return;
    end
    ice_n = w ? d[0] : m_ice;
    sce_n = w ? d[2] : m_sce;
    n_n   = w ? d[15:8] : m_n;
    half  = (n_n == 0) ? 1 : int'(n_n);
    if (!ice_n) begin
      m_mode = M_OFF;
      m_sd   = 0;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_STAB; m_stab_left = STABLE_CYCLES; end
        M_STAB: begin
          m_stab_left--;
          if (m_stab_left == 0) m_mode = M_READY;
        end
        M_READY: if (sce_n) begin m_mode = M_RUN; m_left = half; end
        M_RUN: begin
          if (m_left == 1) begin
            m_sd = !m_sd;
            m_rise = m_sd;
            m_fall = !m_sd;
            m_left = half;
            if (!m_sd && !sce_n) m_mode = M_READY;
            else if (!m_sd && s && AUTO) m_mode = M_PAUSE;
          end else if (!sce_n && !m_sd) m_mode = M_READY;
          else m_left--;
        end
        M_PAUSE: begin
          if (!sce_n) m_mode = M_READY;
          else if (!s) begin m_mode = M_RUN; m_left = half; end
        end
        default: m_mode = M_OFF;
      endcase
    end
    m_ice = ice_n;
    m_sce = sce_n;
    m_n   = n_n;
  endtask

  function automatic logic [19:0] expv();
    logic stable;
    stable = (m_mode == M_READY) || (m_mode == M_RUN) || (m_mode == M_PAUSE);
    return {m_n, 5'b0, m_sce, stable, m_ice, m_sd, m_rise, m_fall, (m_mode == M_PAUSE)};
  endfunction

  task automatic cyc(input logic r, input logic w, input logic [15:0] d, input logic s, input string nm);
    ex_reset = r; clk_ctrl_wr = w; clk_ctrl_in = d; stop_req = s;
    model_step(r, w, d, s);
    exp_q.push_back(expv());
    name_q.push_back(nm);
    @(negedge ex_clk);
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, stop_lvl, nm);
  endtask

  task automatic wr(input logic [15:0] d, input string nm);
    cyc(1'b0, 1'b1, d, stop_lvl, nm);
  endtask

  task automatic wait_high(input string nm);
    for (int k = 0; k < 64 && !m_sd; k++) idle(1, nm);
  endtask

  // monitor: one expected entry per clock edge
  initial begin
    logic [19:0] got, exp;
    string nm;
    forever begin
      @(posedge ex_clk);
      #1;
      n_cyc++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {clk_ctrl_out, sd_clk, sd_clk_rise, sd_clk_fall, clk_paused};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          if (n_fail <= 30)
            $display("FAIL %s cyc=%0d got{ctrl,sd,rise,fall,paused}=%h expected=%h", nm, n_cyc, got, exp);
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, "reset");
    cyc(1'b1, 1'b1, 16'hFFFF, 1'b1, "reset_hold");
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, "reset");
    idle(2, "post_reset");
    wr(16'h0001, "stab_wr");
    idle(20, "stab");
    wr(16'h0405, "run_n4_wr");
    idle(30, "run_n4");
    wait_high("div_wait");
    idle(1, "div_wait");
    wr(16'h0105, "div_change");
    idle(20, "div_n1");
    wr(16'h0405, "sce_prep");
    idle(10, "sce_prep");
    wait_high("sce_wait");
    wr(16'h0401, "sce_off");
    idle(20, "sce_off_idle");
    wr(16'h0405, "stop_prep");
    idle(13, "stop_prep");
    stop_lvl = 1;
    idle(20, "stop_req");
    stop_lvl = 0;
    idle(15, "stop_release");
    wait_high("rst_wait");
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, "reset_mid");
    wr(16'h0001, "restab_wr");
    idle(20, "restab");
    wr(16'h0005, "n0_wr");
    idle(12, "n0_run");
    wait_high("ice_wait");
    wr(16'h0304, "ice_off");
    idle(5, "ice_off_idle");
    // randomized phase: sparse writes, held stop_req, rare resets
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) stop_lvl = ~stop_lvl;
      if ($urandom_range(0, 249) == 0) begin
        cyc(1'b1, 1'b0, 16'h0000, stop_lvl, "rand_reset");
      end else if ($urandom_range(0, 9) == 0) begin
        d = 16'($urandom);
        d[15:8] = 8'($urandom_range(0, 5));
        d[0] = ($urandom_range(0, 9) != 0);
        wr(d, "rand_wr");
      end else begin
        idle(1, "rand");
      end
    end
    stop_lvl = 0;
    idle(3, "drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
- Parametrised successor to the single-bit internal clock gate in the SD host datapath.
- Implements the Clock Control register semantics:
  - internal clock enable (bit 0)
  - internal clock stable (bit 1)
  - SD clock enable (bit 2)
  - SDCLK frequency select (bits 15:8)
- Generates a registered, glitch-free, divided SDCLK plus single-cycle edge strobes for the command and data shifters.
- Sits between the regbank clk_ctrl register and the SD bus PHY logic.

Parameters:
- DIV_W, 8, width of the frequency-select field; divider value N uses bits [8+DIV_W-1:8]
- STABLE_CYCLES, 16, ex_clk cycles after internal enable before the stable bit sets (>=1)
- CNT_W, 16, width of the stabilisation counter

Ports:
- ex_clk  input  1  system clock; only clock in the block
- ex_reset  input  1  synchronous, active-high reset
- clk_ctrl_in  input  16  write data from register interface
- clk_ctrl_wr  input  1  one-cycle write strobe for clk_ctrl_in
- clk_ctrl_out  output  16  readback: written fields, with bit 1 = live stable status
- stop_req  input  1  datapath request to pause SDCLK (buffer full/empty)
- sd_clk  output  1  divided SD bus clock (registered)
- sd_clk_rise  output  1  one-cycle strobe, asserted in the ex_clk cycle sd_clk goes 0->1
- sd_clk_fall  output  1  one-cycle strobe, asserted in the ex_clk cycle sd_clk goes 1->0
- clk_paused  output  1  high while SDCLK is held low due to stop_req

Behaviour:
- Reset values:
  - All outputs 0 (clk_ctrl_out=16'h0000, sd_clk=0, strobes=0, clk_paused=0).
  - State OFF; counters 0.
- Register write:
  - clk_ctrl_wr latches bits 0, 2 and 15:8; bit 1 is read-only and bits 7:3 read 0.
  - Readback reflects the new value the cycle after the strobe.
- Divide ratio:
  - Half-period = max(N,1) ex_clk cycles, i.e. SDCLK = ex_clk/(2*max(N,1)).
  - N=0 is treated as N=1.
  - The half-period counter counts 0..max(N,1)-1 and toggles sd_clk on terminal count.
- States:
  - OFF: internal enable=0. sd_clk=0, stable=0. Enable=1 -> STAB with counter cleared.
  - STAB: counter increments each cycle. At count STABLE_CYCLES-1 -> READY, stable=1 from the next cycle. Enable=0 -> OFF.
  - READY: stable=1, sd_clk=0. SD clock enable=1 -> RUN, with the first rising edge after one full half-period.
  - RUN:
    - Toggles sd_clk.
    - SD clock enable=0 -> completes the current high phase, then returns to READY with sd_clk=0; never produces a runt pulse.
    - Internal enable=0 -> OFF immediately, sd_clk forced 0.
  - PAUSE: see Optional Feature.
- Divider change while running:
  - The new N is taken only at the next toggle point.
  - The current half-period always completes with its old length.
- Strobes:
  - Exactly one strobe per sd_clk transition, coincident with the registered output change.
  - No strobes outside RUN.
- Simultaneous events:
  - Internal enable=0 overrides everything.
  - A write clearing SD clock enable in the same cycle as a terminal count takes effect after that toggle.
- Reset mid-operation returns to the reset values on the next ex_clk edge, regardless of state.

Optional Feature:
- Macro: SD_CLK_AUTO_STOP_EN.
- When defined:
  - In RUN, stop_req=1 causes a transition to PAUSE at the next falling toggle; sd_clk stays 0 and clk_paused=1.
  - stop_req=0 returns to RUN; the next rising edge occurs after one full half-period.
  - Disabling the SD clock while in PAUSE -> READY; internal disable -> OFF.
- When undefined:
  - stop_req is ignored, clk_paused is tied to 0 and the PAUSE state does not exist.

Decomposition:
- Shared package sd_hc_pkg:
  - state encoding (OFF, STAB, READY, RUN, PAUSE)
  - clk_ctrl bit-index constants (ICE=0, ICS=1, SCE=2, FS_LSB=8)
- One sub-module, sd_clk_div: the half-period counter plus toggle flop with edge strobes, parametrised by DIV_W.
- The top-level sd_clk_gen holds the FSM, the register and the stabilisation counter.

Test Plan:
- Write 16'h0001, STABLE_CYCLES=16 -> clk_ctrl_out bit 1 rises exactly 16 cycles after the write takes effect; readback 16'h0003.
- Write 16'h0405 once stable -> sd_clk period 8 ex_clk cycles, 50% duty; sd_clk_rise/sd_clk_fall alternate every 4 cycles.
- While running N=4, write N=1 (16'h0105) mid-high-phase -> the current half-period finishes at 4 cycles, after which the period is 2 cycles; no pulse shorter than 1 cycle.
- Write 16'h0401 while sd_clk=1 -> the high phase completes, sd_clk returns to 0 and stays 0; no strobes afterwards; bit 1 stays 1.
- SD_CLK_AUTO_STOP_EN: assert stop_req for 20 cycles during RUN -> sd_clk parks low at the next fall, clk_paused=1; after release, the first rise follows 4 cycles later.
- Assert ex_reset during RUN -> next cycle all outputs 0 and clk_ctrl_out=0; write 16'h0001 restarts stabilisation from count 0.
